// File: rtl/sdadc_pkg.sv
// Shared widths, defaults and input-clamp helpers for the multi-channel sigma-delta front end.
package sdadc_pkg;

  localparam int SDADC_CHANNELS_DEFAULT   = 4;
  localparam int SDADC_RESOLUTION_DEFAULT = 6;
  localparam int SDADC_WINDOW_MAX_DEFAULT = 128;
  localparam int SDADC_DECIM_W_DEFAULT    = 8;

  // Width able to hold a count of 0..window_max ones.
  function automatic int sum_width(input int window_max);
    return $clog2(window_max + 1);
  endfunction

  // Boxcar length actually used: 0 behaves as 1, oversize requests pin to the history depth.
  function automatic int eff_window(input int window, input int window_max);
    int r;
    if (window == 0) begin
      r = 1;
    end else if (window > window_max) begin
      r = window_max;
    end else begin
      r = window;
    end
    return r;
  endfunction

  function automatic int eff_decim(input int decim);
    int r;
    if (decim == 0) begin
      r = 1;
    end else begin
      r = decim;
    end
    return r;
  endfunction

endpackage

// File: rtl/sdadc_if.sv
// Comparator, configuration and decimated-sample bundle between the sigma-delta front end and its user.
interface sdadc_if
  import sdadc_pkg::*;
#(
  parameter int CHANNELS   = SDADC_CHANNELS_DEFAULT,
  parameter int RESOLUTION = SDADC_RESOLUTION_DEFAULT,
  parameter int WINDOW_MAX = SDADC_WINDOW_MAX_DEFAULT,
  parameter int DECIM_W    = SDADC_DECIM_W_DEFAULT
);

  localparam int SW = sum_width(WINDOW_MAX);

  logic [CHANNELS-1:0]            lvds;
  logic [CHANNELS-1:0]            feedback;
  logic [SW-1:0]                  window;
  logic [DECIM_W-1:0]             decim;
  logic                           enable;
  logic [CHANNELS*RESOLUTION-1:0] sample_data;
  logic                           sample_valid;
  logic                           settled;
  logic [CHANNELS-1:0]            overload;

  modport master (
    output lvds, window, decim, enable,
    input  feedback, sample_data, sample_valid, settled, overload
  );

  modport slave (
    input  lvds, window, decim, enable,
    output feedback, sample_data, sample_valid, settled, overload
  );

endinterface

// File: rtl/sdadc_channel.sv
// One modulator channel: feedback flop, boxcar history and running sum, output saturator.
// SDADC_OVERLOAD_EN adds a run-length counter driving o_overload; otherwise o_overload is tied low.
module sdadc_channel
  import sdadc_pkg::*;
#(
  parameter int RESOLUTION = SDADC_RESOLUTION_DEFAULT,
  parameter int WINDOW_MAX = SDADC_WINDOW_MAX_DEFAULT,
  localparam int SW        = sum_width(WINDOW_MAX)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_lvds,
  input  logic [SW-1:0]         i_wl,
  input  logic                  i_clear,
  output logic                  o_feedback,
  output logic [RESOLUTION-1:0] o_sample,
  output logic                  o_overload
);

  localparam int IW      = $clog2(WINDOW_MAX);
  localparam int SAT_MAX = (1 << RESOLUTION) - 1;

  logic                  r_feedback;
  logic [WINDOW_MAX-1:0] r_hist;
  logic [SW-1:0]         r_sum;
  logic [IW-1:0]         w_tap_idx;
  logic                  w_tap;
  logic [SW-1:0]         w_sum_next;

  // Tap the bit leaving the window; the sum stays equal to the ones held in hist[0..wl-1].
  always_comb begin
    w_tap_idx  = IW'(i_wl - SW'(1));
    w_tap      = r_hist[w_tap_idx];
    w_sum_next = r_sum + SW'(r_feedback) - SW'(w_tap);
  end

  // The comparator bit is registered unconditionally so the modulator loop never stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_feedback <= 1'b0;
      r_hist     <= {WINDOW_MAX{1'b0}};
      r_sum      <= {SW{1'b0}};
    end else begin
      r_feedback <= i_lvds;
      if (i_clear) begin
        r_hist <= {WINDOW_MAX{1'b0}};
        r_sum  <= {SW{1'b0}};
      end else begin
        r_hist <= {r_hist[WINDOW_MAX-2:0], r_feedback};
        r_sum  <= w_sum_next;
      end
    end
  end

  // Saturate rather than wrap when the window can exceed the output range.
  always_comb begin
    if (32'(r_sum) > SAT_MAX) begin
      o_sample = {RESOLUTION{1'b1}};
    end else begin
      o_sample = RESOLUTION'(r_sum);
    end
  end

  assign o_feedback = r_feedback;

`ifdef SDADC_OVERLOAD_EN
  localparam int RW = SW + 1;

  logic [RW-1:0] r_run;
  logic [RW-1:0] w_run_next;
  logic          r_overload;

  // Length of the current run of identical bits entering the history, saturating.
  always_comb begin
    if ((r_run != {RW{1'b0}}) && (r_feedback == r_hist[0])) begin
      if (r_run == {RW{1'b1}}) begin
        w_run_next = r_run;
      end else begin
        w_run_next = r_run + RW'(1);
      end
    end else begin
      w_run_next = RW'(1);
    end
  end

  // A run of twice the window means the modulator is pinned to a rail.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_run      <= {RW{1'b0}};
      r_overload <= 1'b0;
    end else if (i_clear) begin
      r_run      <= {RW{1'b0}};
      r_overload <= 1'b0;
    end else begin
      r_run      <= w_run_next;
      r_overload <= (w_run_next >= {i_wl, 1'b0});
    end
  end

  assign o_overload = r_overload;
`else
  assign o_overload = 1'b0;
`endif

endmodule

// File: rtl/sdadc_frontend.sv
// Multi-channel 1-bit sigma-delta front end: shared window/decimation control over per-channel boxcars.
// Optional run-length overload detection is built when SDADC_OVERLOAD_EN is defined.
module sdadc_frontend
  import sdadc_pkg::*;
#(
  parameter int CHANNELS   = SDADC_CHANNELS_DEFAULT,
  parameter int RESOLUTION = SDADC_RESOLUTION_DEFAULT,
  parameter int WINDOW_MAX = SDADC_WINDOW_MAX_DEFAULT,
  parameter int DECIM_W    = SDADC_DECIM_W_DEFAULT
) (
  input logic   clk,
  input logic   reset_n,
  sdadc_if.slave io_adc
);

  localparam int SW = sum_width(WINDOW_MAX);

  logic [SW-1:0]                  r_wl;
  logic [SW-1:0]                  w_wl_in;
  logic [SW-1:0]                  r_fill;
  logic [SW-1:0]                  w_fill_next;
  logic                           w_change;
  logic                           r_settled;
  logic [DECIM_W-1:0]             w_dm;
  logic [DECIM_W-1:0]             r_dcnt;
  logic [DECIM_W-1:0]             w_dcnt_next;
  logic                           w_strobe;
  logic                           r_sample_valid;
  logic [CHANNELS*RESOLUTION-1:0] r_sample_data;
  logic [CHANNELS*RESOLUTION-1:0] w_samples;
  logic [CHANNELS-1:0]            w_feedback;
  logic [CHANNELS-1:0]            w_overload;

  // r_wl resets to 0, which no clamped window equals, so the first edge after reset is a clear.
  always_comb begin
    w_wl_in  = SW'(eff_window(int'(io_adc.window), WINDOW_MAX));
    w_dm     = DECIM_W'(eff_decim(int'(io_adc.decim)));
    w_change = (w_wl_in != r_wl);
    if (w_change) begin
      w_fill_next = {SW{1'b0}};
    end else if (r_fill == r_wl) begin
      w_fill_next = r_fill;
    end else begin
      w_fill_next = r_fill + SW'(1);
    end
  end

  // Decimator: a lowered ratio below the current count wraps without a strobe.
  always_comb begin
    w_strobe = io_adc.enable && (r_dcnt == (w_dm - DECIM_W'(1))) && r_settled && !w_change;
    if (!io_adc.enable) begin
      w_dcnt_next = {DECIM_W{1'b0}};
    end else if (r_dcnt >= (w_dm - DECIM_W'(1))) begin
      w_dcnt_next = {DECIM_W{1'b0}};
    end else begin
      w_dcnt_next = r_dcnt + DECIM_W'(1);
    end
  end

  // Shared window tracking, fill/settled status, decimation count and sample latch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wl           <= {SW{1'b0}};
      r_fill         <= {SW{1'b0}};
      r_settled      <= 1'b0;
      r_dcnt         <= {DECIM_W{1'b0}};
      r_sample_valid <= 1'b0;
      r_sample_data  <= {(CHANNELS*RESOLUTION){1'b0}};
    end else begin
      r_wl           <= w_wl_in;
      r_fill         <= w_fill_next;
      r_settled      <= !w_change && (w_fill_next == w_wl_in);
      r_dcnt         <= w_dcnt_next;
      r_sample_valid <= w_strobe;
      if (w_strobe) begin
        r_sample_data <= w_samples;
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    sdadc_channel #(
      .RESOLUTION (RESOLUTION),
      .WINDOW_MAX (WINDOW_MAX)
    ) u_ch (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_lvds     (io_adc.lvds[c]),
      .i_wl       (r_wl),
      .i_clear    (w_change),
      .o_feedback (w_feedback[c]),
      .o_sample   (w_samples[c*RESOLUTION +: RESOLUTION]),
      .o_overload (w_overload[c])
    );
  end

  assign io_adc.feedback     = w_feedback;
  assign io_adc.sample_data  = r_sample_data;
  assign io_adc.sample_valid = r_sample_valid;
  assign io_adc.settled      = r_settled;
  assign io_adc.overload     = w_overload;

endmodule

// File: tb/tb_sdadc_frontend.sv
// Two front ends (5-bit and 3-bit outputs) share directed and random stimulus; a bit-queue model predicts outputs.
module tb_sdadc_frontend;

  localparam int CH   = 2;
  localparam int WMAX = 16;
  localparam int RA   = 5;
  localparam int RB   = 3;
  localparam int DW   = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [CH-1:0] lvds;
  logic [4:0]    win;
  logic [DW-1:0] dec;
  logic          en;

  sdadc_if #(.CHANNELS(CH), .RESOLUTION(RA), .WINDOW_MAX(WMAX), .DECIM_W(DW)) if_a ();
  sdadc_if #(.CHANNELS(CH), .RESOLUTION(RB), .WINDOW_MAX(WMAX), .DECIM_W(DW)) if_b ();

  assign if_a.lvds = lvds;  assign if_a.window = win;  assign if_a.decim = dec;  assign if_a.enable = en;
  assign if_b.lvds = lvds;  assign if_b.window = win;  assign if_b.decim = dec;  assign if_b.enable = en;

  sdadc_frontend #(.CHANNELS(CH), .RESOLUTION(RA), .WINDOW_MAX(WMAX), .DECIM_W(DW))
    dut_a (.clk(clk), .reset_n(reset_n), .io_adc(if_a));
  sdadc_frontend #(.CHANNELS(CH), .RESOLUTION(RB), .WINDOW_MAX(WMAX), .DECIM_W(DW))
    dut_b (.clk(clk), .reset_n(reset_n), .io_adc(if_b));

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: bits that entered the history since the last clear, newest last.
  bit            mq [CH][$];
  int            m_wl;
  int            m_dcnt;
  logic [CH-1:0] m_fb;
  int            m_run  [CH];
  int            m_da   [CH];
  int            m_db   [CH];
  bit            m_valid;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int wsum(input int c);
    int s;
    int n;
    s = 0;
    n = mq[c].size();
    for (int i = (n > m_wl) ? n - m_wl : 0; i < n; i++) s += int'(mq[c][i]);
    return s;
  endfunction

  function automatic bit m_settled();
    return (m_wl != 0) && (mq[0].size() >= m_wl);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      mq[c].delete();
      m_run[c] = 0;
      m_da[c]  = 0;
      m_db[c]  = 0;
    end
    m_wl = 0; m_dcnt = 0; m_fb = '0; m_valid = 1'b0;
  endtask

  task automatic model_edge();
    int  new_wl;
    int  dm;
    bit  chg;
    bit  strobe;
    new_wl = (win == 5'd0) ? 1 : imin(int'(win), WMAX);
    dm     = (dec == '0) ? 1 : int'(dec);
    chg    = (new_wl != m_wl);
    strobe = en && (m_dcnt == dm - 1) && m_settled() && !chg;
    if (strobe) begin
      for (int c = 0; c < CH; c++) begin
        m_da[c] = imin(wsum(c), (1 << RA) - 1);
        m_db[c] = imin(wsum(c), (1 << RB) - 1);
      end
    end
    m_valid = strobe;
    if (!en || m_dcnt >= dm - 1) m_dcnt = 0;
    else m_dcnt++;
    for (int c = 0; c < CH; c++) begin
      if (chg) begin
        mq[c].delete();
        m_run[c] = 0;
      end else begin
        if (m_run[c] != 0 && mq[c][mq[c].size()-1] == m_fb[c]) m_run[c]++;
        else m_run[c] = 1;
        mq[c].push_back(m_fb[c]);
        if (mq[c].size() > 2*WMAX) void'(mq[c].pop_front());
      end
    end
    m_fb = lvds;
    m_wl = new_wl;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [CH-1:0] exp_ov;
    int exp_da;
    int exp_db;
    for (int c = 0; c < CH; c++) begin
`ifdef SDADC_OVERLOAD_EN
      exp_ov[c] = (m_wl != 0) && (m_run[c] >= 2*m_wl);
`else
      exp_ov[c] = 1'b0;
`endif
    end
    exp_da = m_da[0] + (m_da[1] << RA);
    exp_db = m_db[0] + (m_db[1] << RB);
    check("feedback_a", 32'(if_a.feedback),     32'(m_fb));
    check("feedback_b", 32'(if_b.feedback),     32'(m_fb));
    check("settled_a",  32'(if_a.settled),      32'(m_settled()));
    check("settled_b",  32'(if_b.settled),      32'(m_settled()));
    check("valid_a",    32'(if_a.sample_valid), 32'(m_valid));
    check("valid_b",    32'(if_b.sample_valid), 32'(m_valid));
    check("data_a",     32'(if_a.sample_data),  32'(exp_da));
    check("data_b",     32'(if_b.sample_data),  32'(exp_db));
    check("overload_a", 32'(if_a.overload),     32'(exp_ov));
    check("overload_b", 32'(if_b.overload),     32'(exp_ov));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  function automatic logic next_bit(input int mode, input logic cur);
    logic b;
    case (mode)
      0:       b = 1'b0;
      1:       b = 1'b1;
      2:       b = ~cur;
      default: b = 1'($urandom_range(0, 1));
    endcase
    return b;
  endfunction

  // mode per channel: 0 low, 1 high, 2 alternating, 3 random
  task automatic drive(input int n, input int mode0, input int mode1);
    for (int i = 0; i < n; i++) begin
      lvds[0] = next_bit(mode0, lvds[0]);
      lvds[1] = next_bit(mode1, lvds[1]);
      cycle();
    end
  endtask

  initial begin
    reset_n = 1'b0;
    lvds = '0; win = 5'd8; dec = 4'd1; en = 1'b1;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    reset_n = 1'b1;

    drive(20, 1, 0);                 // constant 1 on ch0, window 8, every cycle
    dec = 4'd4;
    drive(24, 2, 3);                 // alternating ch0 -> 4, strobe every 4th cycle
    win = 5'd4;
    drive(20, 2, 3);                 // shrink window while running -> refill then 2
    win = 5'd16;
    drive(30, 1, 2);                 // full window of ones saturates the 3-bit build
    win = 5'd8; dec = 4'd1;
    drive(20, 1, 1);                 // long run of ones
    drive(1, 0, 0);                  // single zero breaks the run
    drive(6, 1, 1);
    win = 5'd0; dec = 4'd0;
    drive(12, 3, 3);                 // 0/0 behave as 1/1

    for (int seg = 0; seg < 25; seg++) begin
      win = 5'($urandom_range(0, 20));
      dec = 4'($urandom_range(0, 15));
      en  = ($urandom_range(0, 3) != 0);
      drive($urandom_range(4, 30), 3, 3);
    end
    en = 1'b1; win = 5'd6; dec = 4'd3;
    drive(10, 3, 3);

    #2;
    reset_n = 1'b0;                  // asynchronous reset mid-stream
    model_reset();
    #1;
    check_all();
    repeat (2) begin
      @(posedge clk);
      #1;
      check_all();
    end
    @(negedge clk);
    reset_n = 1'b1;
    win = 5'd8; dec = 4'd1;
    drive(15, 1, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
